// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard and issue interlock.
// Define RF_BYPASS_EN to forward same-cycle writeback data and clear hazards early.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2,
    parameter int CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    input  logic                         issue_valid,
    input  logic                         issue_wr,
    input  logic [ADDR_W-1:0]            issue_dst,
    output logic                         issue_ready,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    output logic [2**ADDR_W-1:0]         busy_vec
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];

    logic            wb_live;
    logic            dec_ok;
    logic            issue_fire;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    assign wb_live    = wb_en && (wb_addr != '0);
    assign dec_ok     = wb_live && (cnt[wb_addr] != '0);
    assign issue_fire = issue_valid && issue_ready && issue_wr
                        && (issue_dst != '0);
    assign inc_vec    = issue_fire ? (NREG'(1) << issue_dst) : '0;
    assign dec_vec    = dec_ok ? (NREG'(1) << wb_addr) : '0;

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        rd_data = '0;
        a = '0;
        d = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            a = rd_addr[k*ADDR_W +: ADDR_W];
            d = regs[a];
            if (BYPASS && wb_live && (wb_addr == a)) begin
                d = wb_data;
            end
            if (a == '0) begin
                d = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = d;
        end
    end

    // A source whose last pending write lands this cycle is released early only with bypass.
    always_comb begin
        logic [ADDR_W-1:0] s;
        logic              b;
        issue_ready = 1'b1;
        s = '0;
        b = 1'b0;
        for (int k = 0; k < RD_PORTS; k++) begin
            s = rd_addr[k*ADDR_W +: ADDR_W];
            b = (s != '0) && busy_vec[s];
            if (BYPASS && dec_ok && (wb_addr == s)
                && (cnt[s] == CNT_W'(1))) begin
                b = 1'b0;
            end
            if (b) begin
                issue_ready = 1'b0;
            end
        end
        if (issue_wr && (issue_dst != '0) && (cnt[issue_dst] == CNT_MAX)) begin
            issue_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
            end
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table, directed hazard
// sequences and randomized traffic against a register/count model.
module tb_regfile_sb;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        issue_valid;
    logic        issue_wr;
    logic [4:0]  issue_dst;
    logic        issue_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy_vec;

    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rd0;
    logic [31:0] rd1;

    assign rd_addr = {ra1, ra0};
    assign rd0 = rd_data[31:0];
    assign rd1 = rd_data[63:32];

    int errors = 0;
    int checks = 0;

    logic [31:0] mreg [32];
    int          mcnt [32];

    regfile_sb dut (
        .clk(clk),
        .rst(rst),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .issue_valid(issue_valid),
        .issue_wr(issue_wr),
        .issue_dst(issue_dst),
        .issue_ready(issue_ready),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit src_busy(input logic [4:0] a);
        if (a == 0 || mcnt[a] == 0) return 1'b0;
        if (BYP && wb_en && wb_addr == a && mcnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_ready();
        if (src_busy(ra0) || src_busy(ra1)) return 1'b0;
        if (issue_wr && issue_dst != 0 && mcnt[issue_dst] == 3) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && wb_en && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int r = 0; r < 32; r++) b[r] = (mcnt[r] != 0);
        return b;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_ready"}, 64'(issue_ready), 64'(model_ready()));
        chk({tag, "_rd0"}, 64'(rd0), 64'(model_rd(ra0)));
        chk({tag, "_rd1"}, 64'(rd1), 64'(model_rd(ra1)));
        chk({tag, "_busy"}, 64'(busy_vec), 64'(model_busy()));
    endtask

    task automatic drive(input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a0,
                         input logic [4:0] a1, input logic iv,
                         input logic iw, input logic [4:0] d);
        wb_en = we;
        wb_addr = wa;
        wb_data = wd;
        ra0 = a0;
        ra1 = a1;
        issue_valid = iv;
        issue_wr = iw;
        issue_dst = d;
    endtask

    // Model advances with the same inputs the DUT samples at this edge.
    task automatic tick();
        bit rdy;
        int dec;
        rdy = model_ready();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                mreg[r] = 0;
                mcnt[r] = 0;
            end
        end else begin
            dec = 0;
            if (wb_en && wb_addr != 0) begin
                mreg[wb_addr] = wb_data;
                if (mcnt[wb_addr] > 0) dec = 1;
                mcnt[wb_addr] -= dec;
            end
            if (issue_valid && rdy && issue_wr && issue_dst != 0)
                mcnt[issue_dst] += 1;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic        iv;
        logic        iw;
        logic [4:0]  dst;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        er;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0,
                    BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b1, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 1'b0, 5'd0,
                    32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0,
                    32'h0, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,
                    32'h0, 32'h0, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'hA5A50001, 5'd31, 5'd0, 1'b1, 1'b1, 5'd2,
                    BYP ? 32'hA5A50001 : 32'h0, 32'h0, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 5'd31, 5'd2, 1'b0, 1'b0, 5'd0,
                    32'hA5A50001, 32'h0, 1'b0, 32'h4};
        vecs[6] = '{1'b1, 5'd2, 32'h77, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0,
                    BYP ? 32'h77 : 32'h0, 32'h0, BYP, 32'h4};
        vecs[7] = '{1'b0, 5'd0, 32'h0, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0,
                    32'h77, 32'h0, 1'b1, 32'h0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        #1;
        chk("reset_busy", 64'(busy_vec), 64'h0);
        chk("reset_ready", 64'(issue_ready), 64'h1);
        chk("reset_rd0", 64'(rd0), 64'h0);
        chk("reset_rd1", 64'(rd1), 64'h0);
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a0,
                  vecs[i].a1, vecs[i].iv, vecs[i].iw, vecs[i].dst);
            #1;
            chk($sformatf("vec%0d_rd0", i), 64'(rd0), 64'(vecs[i].e0));
            chk($sformatf("vec%0d_rd1", i), 64'(rd1), 64'(vecs[i].e1));
            chk($sformatf("vec%0d_ready", i), 64'(issue_ready), 64'(vecs[i].er));
            chk($sformatf("vec%0d_busy", i), 64'(busy_vec), 64'(vecs[i].eb));
            tick();
        end

        // RAW hazard on a source, released by writeback
        drive(0, 0, 0, 0, 0, 1, 1, 5);
        #1 chk("raw_issue_ready", 64'(issue_ready), 64'h1);
        tick();
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        #1;
        chk("raw_stall", 64'(issue_ready), 64'h0);
        chk("raw_busy5", 64'(busy_vec[5]), 64'h1);
        tick();
        drive(1, 5, 32'h12, 0, 5, 0, 0, 0);
        #1;
        chk("raw_wb_ready", 64'(issue_ready), 64'(BYP));
        chk("raw_wb_rd1", 64'(rd1), BYP ? 64'h12 : 64'h0);
        tick();
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        #1;
        chk("raw_after_ready", 64'(issue_ready), 64'h1);
        chk("raw_after_rd1", 64'(rd1), 64'h12);
        chk("raw_after_busy5", 64'(busy_vec[5]), 64'h0);
        tick();

        // destination counter saturation
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 1, 7);
            #1 chk($sformatf("sat_issue%0d", i), 64'(issue_ready), 64'h1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 1, 7);
        #1;
        chk("sat_full_ready", 64'(issue_ready), 64'h0);
        chk("sat_busy7", 64'(busy_vec[7]), 64'h1);
        tick();
        drive(1, 7, 32'h70, 0, 0, 1, 1, 7);
        #1 chk("sat_wb_ready", 64'(issue_ready), 64'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        #1 chk("sat_release_ready", 64'(issue_ready), 64'h1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 7, 32'h71, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 7, 0, 0, 0, 0);
        #1;
        chk("sat_drained_busy7", 64'(busy_vec[7]), 64'h0);
        chk("sat_drained_rd0", 64'(rd0), 64'h71);
        tick();

        // simultaneous issue and writeback to one register
        drive(0, 0, 0, 0, 0, 1, 1, 9);
        tick();
        drive(1, 9, 32'h99, 0, 0, 1, 1, 9);
        #1 chk("same_ready", 64'(issue_ready), 64'h1);
        tick();
        drive(0, 0, 0, 9, 0, 0, 0, 0);
        #1;
        chk("same_busy9", 64'(busy_vec[9]), 64'h1);
        chk("same_rd0", 64'(rd0), 64'h99);
        tick();
        drive(1, 9, 32'h9A, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("same_cleared_busy", 64'(busy_vec), 64'h0);
        tick();

        // reset mid-operation wins over concurrent issue and writeback
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1, 1, 4);
            tick();
        end
        drive(1, 4, 32'h44, 0, 0, 1, 1, 4);
        #1 chk("rst_pre_busy4", 64'(busy_vec[4]), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            drive(0, 0, 0, 5'(i), 5'(i + 1), 0, 0, 0);
            #1;
            chk($sformatf("rst_rd%0d", i), 64'(rd0), 64'h0);
            chk($sformatf("rst_rd%0d", i + 1), 64'(rd1), 64'h0);
            chk("rst_busy", 64'(busy_vec), 64'h0);
            tick();
        end
        drive(1, 4, 32'hABCD, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 4, 0, 0, 0, 0);
        #1;
        chk("post_rst_wb_rd", 64'(rd0), 64'hABCD);
        chk("post_rst_wb_busy", 64'(busy_vec), 64'h0);
        tick();

        // randomized traffic on a small index window to force conflicts
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                  $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)));
            #1 check_model("rnd");
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width; register count is 2**ADDR_W.
REQ-003 Parameter RD_PORTS, default 2, number of independent read/source ports.
REQ-004 Parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rd_addr  input  RD_PORTS*ADDR_W  read/source indices; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  RD_PORTS*DATA_W  read data, same packing.
REQ-009 issue_valid  input  1  decode stage offers an instruction whose sources are rd_addr.
REQ-010 issue_wr  input  1  offered instruction writes register issue_dst.
REQ-011 issue_dst  input  ADDR_W  destination index.
REQ-012 issue_ready  output  1  instruction may issue this cycle.
REQ-013 wb_en  input  1  writeback strobe.
REQ-014 wb_addr  input  ADDR_W  writeback index.
REQ-015 wb_data  input  DATA_W  writeback value.
REQ-016 busy_vec  output  2**ADDR_W  bit r set when register r has a nonzero pending count.

Function
REQ-017 Register 0 reads 0 always; writes and issues to index 0 are ignored for data and counters.
REQ-018 Reads are combinational; a write with wb_en=1 is stored at the clock edge and visible on rd_data the following cycle (same cycle under REQ-029).
REQ-019 Issue handshake: issue accepted in a cycle iff issue_valid && issue_ready; issue_ready is independent of issue_valid.
REQ-020 issue_ready=0 when any port's rd_addr (nonzero) is busy and not cleared this cycle per REQ-029/REQ-030, or when issue_wr=1 and the count of issue_dst (nonzero) equals 2**CNT_W-1.
REQ-021 Accepted issue with issue_wr=1 and issue_dst!=0 increments count[issue_dst] by 1 at the edge.
REQ-022 wb_en=1, wb_addr!=0 with count[wb_addr]>0 decrements that count by 1; with count 0 the data is written and the count stays 0 (no underflow).
REQ-023 Same-cycle increment and decrement of the same register leave its count unchanged.
REQ-024 Writeback proceeds regardless of issue_valid/issue_ready; writeback is never stalled.
REQ-025 busy_vec reflects registered counts only (no combinational bypass).

Reset
REQ-026 On rst=1 at a clock edge: all registers 0, all counts 0, busy_vec all 0; issue_ready then 1 when no destination saturation exists.
REQ-027 rst has priority over simultaneous issue and writeback in the same cycle; both are discarded.
REQ-028 Reset mid-operation drops all pending counts; later writebacks to those indices behave per REQ-022 (count 0).

Configuration
REQ-029 With RF_BYPASS_EN defined: a read port whose nonzero rd_addr equals wb_addr while wb_en=1 returns wb_data in the same cycle, and a source whose count is 1 and is decremented this cycle is treated as not busy for REQ-020.
REQ-030 Without RF_BYPASS_EN: rd_data returns the stored value only, and a source being written back this cycle stays busy until the following cycle (one extra stall cycle).

Verification
REQ-031 After reset, wb_en=1 wb_addr=3 wb_data=0xDEADBEEF; next cycle rd_addr port0=3 -> rd_data port0=0xDEADBEEF, busy_vec=0.
REQ-032 Issue issue_wr=1 dst=5; next cycle offer rd_addr port1=5 -> issue_ready=0, busy_vec[5]=1; writeback to 5 with 0x12 -> bypass: ready=1 and rd_data=0x12 same cycle; no bypass: ready=1 one cycle later.
REQ-033 Three accepted issues to dst=7 (CNT_W=2) -> count 3, fourth issue with issue_wr=1 dst=7 sees issue_ready=0; one writeback to 7 -> ready=1 next cycle.
REQ-034 Issue to dst=9 and writeback to 9 in the same cycle with count 1 -> count stays 1, busy_vec[9]=1.
REQ-035 wb_en=1 wb_addr=0 wb_data=0xFFFFFFFF, issue dst=0 -> rd_data for index 0 stays 0, busy_vec[0]=0, issue_ready=1.
REQ-036 With count[4]=2, assert rst for one cycle with concurrent issue to 4 -> busy_vec=0, all registers read 0 afterwards.
